// File: rtl/fpu_issue_ctrl.sv
// Purpose : issue controller in front of the FP coprocessor; decodes core instructions,
//           drives opcode/addresses/load data for one cycle, then holds off for the op latency.
// Latency : handshake -> ISSUE next cycle; sw store_valid 2 cycles after ISSUE.
// Backpr. : instr_ready only in IDLE (at most one instruction per 2 cycles; longer after mul/div/rev/sw).
// Ports   : clk, reset (sync, active-high); instr_valid/instr_ready/instr/load_data from the core;
//           opcode/addr_reg_in1/addr_reg_in2/addr_destination/inputdata_float to the coprocessor;
//           outdata_float from the coprocessor; store_valid/store_data, illegal, busy to the core.
module fpu_issue_ctrl #(
    parameter int LAT_MUL = 2,
    parameter int LAT_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] load_data,
    output logic [5:0]  opcode,
    output logic [4:0]  addr_reg_in1,
    output logic [4:0]  addr_reg_in2,
    output logic [4:0]  addr_destination,
    output logic [31:0] inputdata_float,
    input  logic [31:0] outdata_float,
    output logic        store_valid,
    output logic [31:0] store_data,
    output logic        illegal,
    output logic        busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    localparam logic [5:0] OP_NOP   = 6'b000000;
    localparam logic [5:0] OP_FIRST = 6'b110000;
    localparam logic [5:0] OP_MUL   = 6'b110010;
    localparam logic [5:0] OP_DIV   = 6'b110011;
    localparam logic [5:0] OP_REV   = 6'b110101;
    localparam logic [5:0] OP_SW    = 6'b111000;
    localparam logic [5:0] OP_LAST  = 6'b111000;

    // Counter preload is latency-1 so that the WAIT state lasts exactly 'latency' cycles.
    localparam logic [3:0] MUL_CNT = (LAT_MUL > 0) ? 4'(LAT_MUL - 1) : 4'd0;
    localparam logic [3:0] DIV_CNT = (LAT_DIV > 0) ? 4'(LAT_DIV - 1) : 4'd0;

    logic [1:0] state;
    logic [3:0] wait_cnt;
    logic [5:0] dec_op;
    logic       legal;
    logic       unused_low_bits;

    // Low instruction bits carry no information for this block.
    assign unused_low_bits = ^instr[10:0];

    assign dec_op      = instr[31:26];
    assign legal       = (dec_op >= OP_FIRST) && (dec_op <= OP_LAST);
    assign instr_ready = (state == S_IDLE) && !reset;
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            wait_cnt         <= 4'd0;
            opcode           <= OP_NOP;
            addr_reg_in1     <= 5'd0;
            addr_reg_in2     <= 5'd0;
            addr_destination <= 5'd0;
            inputdata_float  <= 32'd0;
            store_data       <= 32'd0;
            store_valid      <= 1'b0;
            illegal          <= 1'b0;
        end else begin
            // Both flags are single-cycle pulses.
            store_valid <= 1'b0;
            illegal     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        if (legal) begin
                            // The output registers double as the holding registers, so the
                            // fields appear on the coprocessor pins in the ISSUE cycle.
                            opcode           <= dec_op;
                            addr_destination <= instr[25:21];
                            addr_reg_in1     <= instr[20:16];
                            addr_reg_in2     <= instr[15:11];
                            inputdata_float  <= load_data;
                            state            <= S_ISSUE;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    // Opcode is live for this one cycle only; addresses and data keep their values.
                    opcode <= OP_NOP;
                    if (opcode == OP_SW) begin
                        state <= S_CAPTURE;
                    end else if ((opcode == OP_MUL) && (LAT_MUL > 0)) begin
                        wait_cnt <= MUL_CNT;
                        state    <= S_WAIT;
                    end else if (((opcode == OP_DIV) || (opcode == OP_REV)) && (LAT_DIV > 0)) begin
                        wait_cnt <= DIV_CNT;
                        state    <= S_WAIT;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                S_CAPTURE: begin
                    // Coprocessor presents the store value in the cycle after the sw issue.
                    store_data  <= outdata_float;
                    store_valid <= 1'b1;
                    state       <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Purpose : scoreboard bench for fpu_issue_ctrl with a small coprocessor register model.
// Latency : expectations carry the cycle in which each output event must appear.
// Backpr. : driver holds instr_valid until instr_ready is seen, bounded by a cycle budget.
module tb_fpu_issue_ctrl;

    localparam logic [5:0] OP_ADD = 6'b110000;
    localparam logic [5:0] OP_SUB = 6'b110001;
    localparam logic [5:0] OP_MUL = 6'b110010;
    localparam logic [5:0] OP_DIV = 6'b110011;
    localparam logic [5:0] OP_CMP = 6'b110100;
    localparam logic [5:0] OP_REV = 6'b110101;
    localparam logic [5:0] OP_RND = 6'b110110;
    localparam logic [5:0] OP_LW  = 6'b110111;
    localparam logic [5:0] OP_SW  = 6'b111000;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] load_data;
    logic [5:0]  opcode;
    logic [4:0]  addr_reg_in1;
    logic [4:0]  addr_reg_in2;
    logic [4:0]  addr_destination;
    logic [31:0] inputdata_float;
    logic [31:0] outdata_float = 32'hDEAD_BEEF;
    logic        store_valid;
    logic [31:0] store_data;
    logic        illegal;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fpu_issue_ctrl #(.LAT_MUL(2), .LAT_DIV(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .load_data        (load_data),
        .opcode           (opcode),
        .addr_reg_in1     (addr_reg_in1),
        .addr_reg_in2     (addr_reg_in2),
        .addr_destination (addr_destination),
        .inputdata_float  (inputdata_float),
        .outdata_float    (outdata_float),
        .store_valid      (store_valid),
        .store_data       (store_data),
        .illegal          (illegal),
        .busy             (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [5:0]  op;
        logic [4:0]  d;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] data;
    } iss_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } st_t;

    iss_t iss_q[$];
    st_t  st_q[$];
    int   ill_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2);
        return {op, d, s1, s2, 11'h5A5};
    endfunction

    // Present one instruction until accepted; records the handshake cycle and the
    // expected downstream event. Returns at the negedge of the cycle after the handshake.
    task automatic send(input logic [31:0] ins, input logic [31:0] ld, output int hs);
        logic [5:0] op;
        bit         got;
        op          = ins[31:26];
        got         = 1'b0;
        hs          = -1;
        instr_valid = 1'b1;
        instr       = ins;
        load_data   = ld;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (instr_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: no ready for instr %h within 40 cycles", ins);
        end else begin
            hs = cyc;
            if (op >= OP_ADD && op <= OP_SW)
                iss_q.push_back('{cyc + 1, op, ins[25:21], ins[20:16], ins[15:11], ld});
            else
                ill_q.push_back(cyc + 1);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = $urandom();
        load_data   = $urandom();
    endtask

    // Coprocessor model: lw writes its src1 register, sw reads it back one cycle after issue.
    logic [31:0] fp [32];
    int          pend_cyc = -1;
    logic [31:0] pend_val = 32'd0;

    always @(negedge clk) begin
        if (opcode == OP_LW) fp[addr_reg_in1] = inputdata_float;
        if (opcode == OP_SW) begin
            pend_cyc = cyc + 1;
            pend_val = fp[addr_reg_in1];
        end
    end

    always @(posedge clk) begin
        #1;
        if (pend_cyc == cyc) outdata_float = pend_val;
        else                 outdata_float = 32'hDEAD_BEEF;
    end

    // Monitor: every output event must match the head of its expectation queue.
    always @(negedge clk) begin
        iss_t e;
        st_t  s;
        int   ic;
        if (cyc > 0) begin
            if (opcode != 6'd0) begin
                if (iss_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: opcode %b at cycle %0d, none expected", opcode, cyc);
                end else begin
                    e = iss_q.pop_front();
                    chk("issue_cycle", cyc, e.cyc);
                    chk("issue_opcode", {26'd0, opcode}, {26'd0, e.op});
                    chk("issue_dest", {27'd0, addr_destination}, {27'd0, e.d});
                    chk("issue_src1", {27'd0, addr_reg_in1}, {27'd0, e.s1});
                    chk("issue_src2", {27'd0, addr_reg_in2}, {27'd0, e.s2});
                    chk("issue_data", inputdata_float, e.data);
                end
            end
            if (store_valid) begin
                if (st_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_store: store_valid at cycle %0d, none expected", cyc);
                end else begin
                    s = st_q.pop_front();
                    chk("store_cycle", cyc, s.cyc);
                    chk("store_data", store_data, s.data);
                end
            end
            if (illegal) begin
                if (ill_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_illegal: illegal at cycle %0d, none expected", cyc);
                end else begin
                    ic = ill_q.pop_front();
                    chk("illegal_cycle", cyc, ic);
                end
            end
        end
    end

    initial begin
        int h0, h1, h2, c0;
        for (int i = 0; i < 32; i++) fp[i] = 32'd0;
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = mk(OP_ADD, 5'd3, 5'd1, 5'd2);
        load_data   = 32'h1111_2222;

        // Reset held with a pending instruction: never ready.
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("ready_in_reset", {31'd0, instr_ready}, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("rst_opcode", {26'd0, opcode}, 32'd0);
        chk("rst_addr", {17'd0, addr_destination, addr_reg_in1, addr_reg_in2}, 32'd0);
        chk("rst_inputdata", inputdata_float, 32'd0);
        chk("rst_store_data", store_data, 32'd0);
        chk("rst_flags", {29'd0, store_valid, illegal, busy}, 32'd0);

        // First handshake in first non-reset cycle; add issues for one cycle.
        c0 = cyc;
        send(mk(OP_ADD, 5'd3, 5'd1, 5'd2), 32'h1111_2222, h0);
        chk("first_hs_cycle", h0, c0);
        #1;
        chk("issue_busy", {31'd0, busy}, 32'd1);
        chk("issue_ready", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("ready_after_add", {31'd0, instr_ready}, 32'd1);
        chk("busy_after_add", {31'd0, busy}, 32'd0);

        // lw then sw of the same register; a new instruction is taken alongside store_valid.
        send(mk(OP_LW, 5'd0, 5'd5, 5'd0), 32'h4049_0FDB, h0);
        send(mk(OP_SW, 5'd0, 5'd5, 5'd0), 32'h0BAD_F00D, h0);
        st_q.push_back('{h0 + 3, 32'h4049_0FDB});
        send(mk(OP_SUB, 5'd7, 5'd8, 5'd9), 32'h3F80_0000, h1);
        chk("hs_after_sw", h1 - h0, 3);
        send(mk(OP_CMP, 5'd10, 5'd11, 5'd12), 32'h0000_0000, h2);
        chk("hs_after_sub", h2 - h1, 2);
        send(mk(OP_RND, 5'd31, 5'd30, 5'd29), 32'hFFFF_FFFF, h0);
        chk("hs_after_cmp", h0 - h2, 2);

        // div with instr_valid held high through the wait.
        send(mk(OP_DIV, 5'd4, 5'd5, 5'd6), 32'h1234_5678, h0);
        instr_valid = 1'b1;
        instr       = mk(OP_ADD, 5'd1, 5'd2, 5'd3);
        load_data   = 32'hA5A5_A5A5;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("div_wait_busy", {31'd0, busy}, 32'd1);
            chk("div_wait_ready", {31'd0, instr_ready}, 32'd0);
            chk("div_wait_nop", {26'd0, opcode}, 32'd0);
        end
        send(mk(OP_ADD, 5'd1, 5'd2, 5'd3), 32'hA5A5_A5A5, h1);
        chk("div_spacing", h1 - h0, 6);

        send(mk(OP_REV, 5'd2, 5'd3, 5'd4), 32'h0000_0005, h0);
        send(mk(OP_ADD, 5'd6, 5'd6, 5'd6), 32'h0000_0006, h1);
        chk("rev_spacing", h1 - h0, 6);

        send(mk(OP_MUL, 5'd11, 5'd12, 5'd13), 32'h0000_0007, h0);
        send(mk(OP_ADD, 5'd9, 5'd8, 5'd7), 32'h0000_0009, h1);
        chk("mul_spacing", h1 - h0, 4);

        // Illegal opcodes: pulse only, nothing issued, coprocessor outputs held.
        @(negedge clk);
        send(mk(6'b101010, 5'd1, 5'd1, 5'd1), 32'hFFFF_0000, h0);
        #1;
        chk("illegal_busy", {31'd0, busy}, 32'd0);
        chk("illegal_nop", {26'd0, opcode}, 32'd0);
        chk("illegal_addr_hold", {17'd0, addr_destination, addr_reg_in1, addr_reg_in2},
            {17'd0, 5'd9, 5'd8, 5'd7});
        chk("illegal_data_hold", inputdata_float, 32'h0000_0009);
        send(mk(OP_ADD, 5'd13, 5'd14, 5'd15), 32'h0000_0077, h1);
        chk("illegal_then_legal", h1 - h0, 1);
        send(mk(6'b111001, 5'd2, 5'd2, 5'd2), 32'h0, h0);
        send(mk(6'b101111, 5'd3, 5'd3, 5'd3), 32'h0, h1);
        chk("illegal_back_to_back", h1 - h0, 1);

        // Reset in the 2nd WAIT cycle of a mul.
        @(negedge clk);
        send(mk(OP_MUL, 5'd6, 5'd7, 5'd8), 32'hCAFE_0001, h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ready_reset_mid", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_opcode", {26'd0, opcode}, 32'd0);
        chk("mid_rst_addr", {17'd0, addr_destination, addr_reg_in1, addr_reg_in2}, 32'd0);
        chk("mid_rst_inputdata", inputdata_float, 32'd0);
        chk("mid_rst_store_data", store_data, 32'd0);
        chk("mid_rst_flags", {29'd0, store_valid, illegal, busy}, 32'd0);

        // Reset during CAPTURE abandons the store.
        @(negedge clk);
        send(mk(OP_SW, 5'd0, 5'd5, 5'd0), 32'h0000_0000, h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("cap_rst_busy", {31'd0, busy}, 32'd0);
        chk("cap_rst_store_valid", {31'd0, store_valid}, 32'd0);

        repeat (5) @(negedge clk);
        chk("store_data_after_abort", store_data, 32'd0);
        chk("iss_q_empty", iss_q.size(), 32'd0);
        chk("st_q_empty", st_q.size(), 32'd0);
        chk("ill_q_empty", ill_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Issue controller directly upstream of the floating-point coprocessor. It accepts 32-bit FP instructions from the integer core over a valid/ready handshake and decodes opcode and register fields. It drives the coprocessor's opcode, address and load-data inputs for exactly one clock per instruction, then holds off further issue for the operation's latency budget. For store instructions it captures the coprocessor's store data and returns it to the core with a one-cycle valid pulse.

Parameters:
LAT_MUL, 2, extra wait cycles after issuing mul (110010); legal range 0..15
LAT_DIV, 4, extra wait cycles after issuing div (110011) or rev (110101); legal range 0..15

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
instr_valid  in  1  core presents an instruction
instr_ready  out  1  controller accepts an instruction this cycle
instr  in  32  [31:26] opcode, [25:21] dest, [20:16] src1, [15:11] src2, [10:0] ignored
load_data  in  32  operand for lw; sampled together with instr
opcode  out  6  to coprocessor; 000000 (NOP) whenever not issuing
addr_reg_in1  out  5  to coprocessor, src1 field
addr_reg_in2  out  5  to coprocessor, src2 field
addr_destination  out  5  to coprocessor, dest field
inputdata_float  out  32  to coprocessor, latched load_data
outdata_float  in  32  from coprocessor; valid the cycle after a sw issue
store_valid  out  1  one-cycle pulse: store_data is valid
store_data  out  32  captured store value; holds until the next capture
illegal  out  1  one-cycle pulse: rejected opcode
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE; opcode 0; all address outputs 0; inputdata_float 0; store_data 0; store_valid 0; illegal 0; wait counter 0. Reset dominates all other inputs, including in the middle of WAIT or CAPTURE. An in-flight instruction is abandoned and no store_valid is produced for it.
- Legal opcodes are 110000 through 111000: add, sub, mul, div, cmp, rev, rnd, lw, sw. All other opcodes are illegal.
- instr_ready = 1 only in IDLE and only while not in reset. A handshake occurs when instr_valid & instr_ready.
- Decode uses instr[31:26] directly at the handshake.
- IDLE:
  - Handshake with an illegal opcode: illegal = 1 in the next cycle. State stays IDLE, nothing is issued, all coprocessor outputs are unchanged.
  - Handshake with a legal opcode: latch opcode and fields into holding registers, latch load_data, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Outputs are registered: opcode and addresses present the latched fields during this cycle only. The coprocessor samples them at the closing edge.
  - Exit to CAPTURE for sw.
  - Exit to WAIT with counter = LAT_MUL-1 for mul when LAT_MUL > 0.
  - Exit to WAIT with counter = LAT_DIV-1 for div/rev when LAT_DIV > 0.
  - Otherwise exit to IDLE.
  - On exit, opcode returns to 000000. Address outputs and inputdata_float hold their last values.
- WAIT: opcode = NOP. The counter decrements each cycle; leave for IDLE in the cycle the counter is 0. Total WAIT cycles = configured latency. A latency of 0 skips WAIT.
- CAPTURE (1 cycle): store_data <= outdata_float at the closing edge, then go to IDLE. store_valid = 1 during the first IDLE cycle after CAPTURE only.
- Throughput: at most one instruction per 2 cycles, i.e. handshake then ISSUE. With an instruction waiting continuously, the next handshake occurs in the first IDLE cycle.
- A new instruction may be accepted in the same cycle that store_valid is high.
- instr and load_data are don't-care outside handshake cycles; the controller must not sample them then.
- busy = (state != IDLE), combinational from state.

Test Plan:
1. Reset held 3 cycles with instr_valid=1 -> instr_ready=0 throughout; after release, all outputs are 0 and the first handshake completes in the first non-reset cycle.
2. add: instr opcode 110000, dest 3, src1 1, src2 2 -> one cycle later opcode=110000 and addr_destination/in1/in2 = 3/1/2 for exactly 1 cycle; instr_ready high again on the following cycle.
3. lw: opcode 110111, src1 5, load_data=0x40490FDB -> during ISSUE, inputdata_float=0x40490FDB and addr_reg_in1=5. sw of src1 5 with a model returning 0x40490FDB -> store_valid is a 1-cycle pulse 2 cycles after the sw ISSUE cycle, with store_data=0x40490FDB.
4. div with LAT_DIV=4 and instr_valid held high -> exactly 4 WAIT cycles with opcode=NOP and busy=1. The next handshake occurs 6 cycles after the div handshake.
5. Opcode 101010 -> illegal pulses 1 cycle, opcode stays 000000, busy stays 0. The next legal instruction is accepted immediately.
6. Assert reset during the 2nd WAIT cycle of a mul with LAT_MUL=2 -> the next cycle is IDLE with all outputs 0 and no late store_valid or opcode activity.
